// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: ISA opcode values, default widths, IF/ID
// control bundle and small decode helpers. Decode imports the same package so
// both stages agree on the opcode map.
package instr_fetch_pkg;

  // Default datapath widths for the fetch stage and its memory port
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W       = 5;

  // Opcode map, taken from the top OPC_W bits of every instruction
  typedef enum logic [4:0] {
    OPC_NOP  = 5'b00000,
    OPC_HALT = 5'b00001,
    OPC_ADDI = 5'b00010,
    OPC_SUBI = 5'b00011,
    OPC_LD   = 5'b00100,
    OPC_ST   = 5'b00101,
    OPC_BEQ  = 5'b01000,
    OPC_BNE  = 5'b01001,
    OPC_JMP  = 5'b01010
  } opcode_e;

  // Architectural register names used by decode
  typedef enum logic [2:0] {
    REG_R0 = 3'd0,
    REG_R1 = 3'd1,
    REG_R2 = 3'd2,
    REG_R3 = 3'd3,
    REG_R4 = 3'd4,
    REG_R5 = 3'd5,
    REG_R6 = 3'd6,
    REG_R7 = 3'd7
  } reg_name_e;

  // Control bundle for one pipeline register: flush wins over load, and
  // neither asserted means hold
  typedef struct packed {
    logic load;
    logic flush;
  } pipe_ctrl_t;

  // True when the opcode field stops the fetch unit
  function automatic logic is_halt(input logic [OPC_W-1:0] opc);
    return (opc == OPC_HALT);
  endfunction

  // True for opcodes that redirect the PC once resolved in EX
  function automatic logic is_branch(input logic [OPC_W-1:0] opc);
    logic result;
    case (opc)
      OPC_BEQ: result = 1'b1;
      OPC_BNE: result = 1'b1;
      OPC_JMP: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// Generic pipeline register carrying instruction, fetch address and valid bit.
// Flush drops the entry to a NOP and clears valid; load captures new
// contents; otherwise the entry holds. The address field is kept on flush,
// since it only has meaning alongside a valid entry.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  pipe_ctrl_t         ctrl,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               valid_r;

  // Pipeline entry update: flush has priority over load, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= {INSTR_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
    end else if (ctrl.flush) begin
      instr_r <= {INSTR_W{1'b0}};
      valid_r <= 1'b0;
    end else if (ctrl.load) begin
      instr_r <= instr_in;
      pc_r    <= pc_in;
      valid_r <= 1'b1;
    end else begin
      instr_r <= instr_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end
  end

  assign instr = instr_r;
  assign pc    = pc_r;
  assign valid = valid_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, drives the combinational-read
// instruction memory directly from the PC and fills the IF/ID register.
// Three states: IDLE waits for start, RUN fetches one instruction per cycle,
// HALTED freezes on a HALT until an older branch squashes it. Per cycle the
// branch redirect beats the hazard stall, which beats a normal fetch.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic              halted_r;
  logic [CNT_W-1:0]  fetch_count_r;
  logic              cnt_inc_s;
  logic              rdata_halt_s;
  pipe_ctrl_t        if_id_ctrl_s;

  // The memory sees the PC itself, so the fetched word arrives this cycle
  assign imem_addr    = pc_r;
  assign rdata_halt_s = is_halt(imem_rdata[INSTR_W-1 -: OPC_W]);

  // Next-state, next-PC and IF/ID control selection
  always_comb begin
    state_nxt_s        = state_r;
    pc_nxt_s           = pc_r;
    if_id_ctrl_s.load  = 1'b0;
    if_id_ctrl_s.flush = 1'b0;
    cnt_inc_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // IF/ID is kept empty; the first fetch happens at the current PC
        if_id_ctrl_s.flush = 1'b1;
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_nxt_s           = branch_target;
          if_id_ctrl_s.flush = 1'b1;
        end else if (stall) begin
          pc_nxt_s = pc_r;
        end else begin
          if_id_ctrl_s.load = 1'b1;
          cnt_inc_s         = 1'b1;
          if (rdata_halt_s) begin
            // PC stays on the HALT so a later squash restarts cleanly
            state_nxt_s = ST_HALTED;
          end else begin
            pc_nxt_s = pc_r + ADDR_W'(1);
          end
        end
      end
      ST_HALTED: begin
        if (branch_taken) begin
          pc_nxt_s           = branch_target;
          if_id_ctrl_s.flush = 1'b1;
          state_nxt_s        = ST_RUN;
        end else if (stall) begin
          // The HALT stays in ID until decode consumes it
          pc_nxt_s = pc_r;
        end else begin
          if_id_ctrl_s.flush = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle fetch unit
        state_nxt_s        = ST_IDLE;
        pc_nxt_s           = RESET_PC;
        if_id_ctrl_s.flush = 1'b1;
      end
    endcase
  end

  // State, PC and halted flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      halted_r <= (state_nxt_s == ST_HALTED);
    end
  end

  // Saturating count of instructions delivered to ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s && (fetch_count_r != {CNT_W{1'b1}})) begin
      fetch_count_r <= fetch_count_r + CNT_W'(1);
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (if_id_ctrl_s),
    .instr_in (imem_rdata),
    .pc_in    (pc_r),
    .instr    (id_instr),
    .pc       (id_pc),
    .valid    (id_valid)
  );

  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run,
// all compared every cycle against a behavioural model of the fetch rules.
// The counter width is reduced so that saturation is reached quickly.
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  logic [INSTR_W-1:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  // reference model state: 0 idle, 1 running, 2 halted
  int                 m_state;
  int                 m_pc;
  logic [INSTR_W-1:0] m_instr;
  int                 m_idpc;
  bit                 m_valid;
  int                 m_cnt;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (8'h00),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  function automatic logic [INSTR_W-1:0] mk(input logic [4:0] opc, input logic [10:0] imm);
    return {opc, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_instr = '0; m_idpc = 0; m_valid = 0; m_cnt = 0;
  endtask

  // One clock of the fetch rules, evaluated with the inputs of this cycle
  task automatic model_step();
    logic [INSTR_W-1:0] w;
    if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (branch_taken) begin
        m_pc = int'(branch_target); m_instr = '0; m_valid = 0;
      end else if (!stall) begin
        w = mem[m_pc];
        m_instr = w; m_idpc = m_pc; m_valid = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (w[15:11] == 5'b00001) m_state = 2;
        else m_pc = (m_pc + 1) % 256;
      end
    end else begin
      if (branch_taken) begin
        m_pc = int'(branch_target); m_instr = '0; m_valid = 0; m_state = 1;
      end else if (!stall) begin
        m_instr = '0; m_valid = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"},   32'(imem_addr), 32'(m_pc));
    chk({tag, ".id_valid"},    32'(id_valid), 32'(m_valid));
    chk({tag, ".id_instr"},    32'(id_instr), 32'(m_instr));
    chk({tag, ".halted"},      32'(halted), 32'(m_state == 2));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
    if (m_valid) chk({tag, ".id_pc"}, 32'(id_pc), 32'(m_idpc));
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare after the edge
  task automatic step(input string tag, input logic s, input logic st,
                      input logic br, input logic [ADDR_W-1:0] tgt);
    start = s; stall = st; branch_taken = br; branch_target = tgt;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = mk(5'b00010, 11'(i));
    mem[1] = mk(5'b00011, 11'd1);
    mem[2] = mk(5'b00001, 11'd0);
    mem[7] = mk(5'b00001, 11'd7);
    model_reset();
    #12;
    check_all("reset");
    chk("reset.id_pc", 32'(id_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: start at cycle 2, run 0:ADDI 1:SUBI 2:HALT
    step("t1.idle", 1'b0, 1'b0, 1'b0, 8'h00);
    step("t1.start", 1'b1, 1'b0, 1'b0, 8'h00);
    step("t1.f0", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1.id_pc0", 32'(id_pc), 32'h0);
    step("t1.f1", 1'b0, 1'b0, 1'b0, 8'h00);
    step("t1.f2", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1.halted", 32'(halted), 32'h1);
    chk("t1.pc", 32'(imem_addr), 32'h2);
    chk("t1.cnt", 32'(fetch_count), 32'h3);
    step("t1.hstall", 1'b0, 1'b1, 1'b0, 8'h00);
    step("t1.hdrop", 1'b1, 1'b0, 1'b0, 8'h00);

    // 2: stall three cycles with pc=4 and an instruction held in ID
    step("t2.br", 1'b0, 1'b0, 1'b1, 8'h03);
    step("t2.f3", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("t2.stall", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("t2.pc_held", 32'(imem_addr), 32'h4);
    chk("t2.idpc_held", 32'(id_pc), 32'h3);
    step("t2.f4", 1'b0, 1'b0, 1'b0, 8'h00);
    step("t2.f5", 1'b0, 1'b0, 1'b0, 8'h00);

    // 3: branch and stall together at pc=6
    step("t3.brst", 1'b0, 1'b1, 1'b1, 8'h20);
    chk("t3.pc", 32'(imem_addr), 32'h20);
    step("t3.f20", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t3.idpc", 32'(id_pc), 32'h20);

    // 4: HALT at 7 squashed by a branch to 1
    step("t4.br7", 1'b0, 1'b0, 1'b1, 8'h07);
    step("t4.f7", 1'b0, 1'b0, 1'b0, 8'h00);
    step("t4.sq", 1'b0, 1'b0, 1'b1, 8'h01);
    chk("t4.unhalt", 32'(halted), 32'h0);
    step("t4.f1", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t4.idpc", 32'(id_pc), 32'h1);

    // 5: linear code across the top of the address space
    step("t5.br", 1'b0, 1'b0, 1'b1, 8'hFC);
    for (int i = 0; i < 6; i++) step("t5.wrap", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t5.idpc", 32'(id_pc), 32'h1);

    // 6: asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.id_pc", 32'(id_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("t6.idle", 1'b0, 1'b0, 1'b1, 8'h40);
    step("t6.idle2", 1'b0, 1'b1, 1'b0, 8'h00);
    step("t6.start", 1'b1, 1'b0, 1'b0, 8'h00);
    step("t6.f0", 1'b0, 1'b0, 1'b0, 8'h00);

    // randomized program and control traffic, long enough to saturate the counter
    for (int i = 0; i < 256; i++) begin
      logic [4:0] opc;
      opc = ($urandom % 10 == 0) ? 5'b00001 : 5'(2 + ($urandom % 30));
      mem[i] = mk(opc, 11'($urandom));
    end
    for (int c = 0; c < 600; c++) begin
      step("rnd", 1'($urandom % 4 == 0), 1'($urandom % 4 == 0),
           1'($urandom % 7 == 0), 8'($urandom));
    end
    chk("rnd.sat", 32'(fetch_count), 32'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
